// File: rtl/cpu_sram_bridge_pkg.sv
// Shared types and helpers for the CPU-to-sram-like bus bridge: FSM encoding,
// bus size codes, request bundle width and the write-enable to size decode.
package cpu_sram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_REQ  = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_I_REQ  = 3'd3,
    ST_I_WAIT = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Latched request bundle is {wen, addr, wdata}.
  function automatic int req_bundle_w(input int addr_w, input int data_w);
    return 4 + addr_w + data_w;
  endfunction

  // Reads and unusual strobe patterns go out as full words.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/cpu_sram_bridge_sram_req_latch.sv
// Per-channel request capture: snapshots {wen, addr, wdata} at the start of a
// pipeline-cycle group and tracks whether that channel still owes a transaction.
module sram_req_latch
  import cpu_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              pend,
  output logic [3:0]        lat_wen,
  output logic [ADDR_W-1:0] lat_addr,
  output logic [DATA_W-1:0] lat_wdata
);

  localparam int REQ_W = req_bundle_w(ADDR_W, DATA_W);

  logic [REQ_W-1:0] req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (capture) begin
      pend <= en;
    end else if (clear) begin
      pend <= 1'b0;
    end
  end

  // Payload needs no reset: it is only consumed while pend is set.
  always_ff @(posedge clk) begin
    if (capture) begin
      req_q <= {wen, addr, wdata};
    end
  end

  assign {lat_wen, lat_addr, lat_wdata} = req_q;

endmodule

// File: rtl/cpu_sram_bridge.sv
// Serializes the core's instruction and data SRAM requests onto one sram-like
// master port (data first, one outstanding), stalling the core until done.
module cpu_sram_bridge
  import cpu_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_wen,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              stall_req,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t            state;
  logic              any_en;
  logic              capture;
  logic              clear_d;
  logic              clear_i;
  logic              pend_d;
  logic              pend_i;
  logic              data_sel;
  logic [3:0]        d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        i_wen;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [3:0]        sel_wen;

  assign any_en  = inst_sram_en | data_sram_en;
  assign capture = (state == ST_IDLE) && any_en;
  assign clear_d = (state == ST_D_WAIT) && bus_data_ok;
  assign clear_i = (state == ST_I_WAIT) && bus_data_ok;

  sram_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data_latch (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .clear     (clear_d),
    .en        (data_sram_en),
    .wen       (data_sram_wen),
    .addr      (data_sram_addr),
    .wdata     (data_sram_wdata),
    .pend      (pend_d),
    .lat_wen   (d_wen),
    .lat_addr  (d_addr),
    .lat_wdata (d_wdata)
  );

  sram_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_inst_latch (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .clear     (clear_i),
    .en        (inst_sram_en),
    .wen       (inst_sram_wen),
    .addr      (inst_sram_addr),
    .wdata     (inst_sram_wdata),
    .pend      (pend_i),
    .lat_wen   (i_wen),
    .lat_addr  (i_addr),
    .lat_wdata (i_wdata)
  );

  // Bus fields come straight from the latches, so they cannot move while a
  // request waits for addr_ok.
  assign data_sel  = (state == ST_D_REQ) || (state == ST_D_WAIT);
  assign sel_wen   = data_sel ? d_wen : i_wen;
  assign bus_addr  = data_sel ? d_addr : i_addr;
  assign bus_wdata = data_sel ? d_wdata : i_wdata;
  assign bus_wr    = |sel_wen;
  assign bus_wstrb = sel_wen;
  assign bus_size  = wen_to_size(sel_wen);

  // Pend flags are set exactly while a transaction of the group is still owed.
  always_comb begin
    stall_req = 1'b0;
    if (rst) begin
      stall_req = 1'b0;
    end else if (state == ST_IDLE) begin
      stall_req = any_en;
    end else if (state != ST_DONE) begin
      stall_req = pend_d | pend_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      bus_req         <= 1'b0;
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_en) begin
            state   <= data_sram_en ? ST_D_REQ : ST_I_REQ;
            bus_req <= 1'b1;
          end
        end
        ST_D_REQ: begin
          if (bus_addr_ok) begin
            state   <= ST_D_WAIT;
            bus_req <= 1'b0;
          end
        end
        ST_D_WAIT: begin
          if (bus_data_ok) begin
            if (d_wen == 4'b0000) begin
              data_sram_rdata <= bus_rdata;
            end
            if (pend_i) begin
              state   <= ST_I_REQ;
              bus_req <= 1'b1;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_I_REQ: begin
          if (bus_addr_ok) begin
            state   <= ST_I_WAIT;
            bus_req <= 1'b0;
          end
        end
        ST_I_WAIT: begin
          if (bus_data_ok) begin
            if (i_wen == 4'b0000) begin
              inst_sram_rdata <= bus_rdata;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Scoreboard bench for cpu_sram_bridge: directed groups push expected bus
// transactions; a monitor checks each accepted request against the queue.
module tb_cpu_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_sram_en = 1'b0;
  logic [3:0]  inst_sram_wen = 4'b0;
  logic [31:0] inst_sram_addr = '0;
  logic [31:0] inst_sram_wdata = '0;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'b0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic        stall_req;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;

  cpu_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stall_req       (stall_req),
    .bus_req         (bus_req),
    .bus_wr          (bus_wr),
    .bus_size        (bus_size),
    .bus_addr        (bus_addr),
    .bus_wstrb       (bus_wstrb),
    .bus_wdata       (bus_wdata),
    .bus_addr_ok     (bus_addr_ok),
    .bus_data_ok     (bus_data_ok),
    .bus_rdata       (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_push = 0;
  int          addr_delay = 0;
  bit          dok_block = 1'b0;
  bit          spur = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    txn_t t;
    t.wr = wr; t.size = size; t.addr = addr; t.wstrb = wstrb;
    t.wdata = wr ? wdata : 32'h0;
    exp_q.push_back(t);
    n_push++;
  endtask

  // Slave model: addr_ok after addr_delay wait cycles, data_ok one cycle after acceptance.
  initial begin : slave
    bit          prev_acc = 1'b0;
    bit          prev_wr = 1'b0;
    bit          pend = 1'b0;
    bit          pend_wr = 1'b0;
    int          wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_acc = 1'b0; pend = 1'b0; wcnt = 0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      end else begin
        if (prev_acc) begin
          pend = 1'b1;
          pend_wr = prev_wr;
        end
        if (pend && !dok_block) begin
          bus_data_ok = 1'b1;
          if (pend_wr) bus_rdata = 32'hFFFF_FFFF;
          else bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
          pend = 1'b0;
        end else if (spur) begin
          bus_data_ok = 1'b1;
          bus_rdata = 32'h5555_5555;
        end else begin
          bus_data_ok = 1'b0;
        end
        bus_addr_ok = 1'b0;
        if (bus_req && !prev_acc) begin
          if (wcnt >= addr_delay) begin
            bus_addr_ok = 1'b1;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
        prev_acc = bus_req && bus_addr_ok;
        prev_wr = bus_wr;
      end
    end
  end

  // Monitor: pops the expected transaction at each accepted request and
  // requires the fields to stay put while the request is held.
  logic       prev_req = 1'b0;
  logic       prev_aok = 1'b0;
  logic [71:0] prev_fields = '0;
  always @(negedge clk) begin
    logic [71:0] cur;
    txn_t e;
    cur = {1'b0, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wr ? bus_wdata : 32'h0};
    if (!rst && bus_req) begin
      if (prev_req && !prev_aok) chk("held fields", cur, prev_fields);
      if (bus_addr_ok) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected txn: got %h, expected none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("bus txn", cur, {1'b0, e.wr, e.size, e.addr, e.wstrb, e.wdata});
        end
      end
    end
    prev_req = bus_req && !rst;
    prev_aok = bus_addr_ok;
    prev_fields = cur;
  end

  task automatic run_group(input bit d_en, input logic [3:0] d_wen, input logic [31:0] d_addr,
                           input logic [31:0] d_wdata, input bit i_en, input logic [31:0] i_addr,
                           input int exp_stall, input string name);
    int cnt;
    @(negedge clk);
    data_sram_en = d_en; data_sram_wen = d_wen; data_sram_addr = d_addr; data_sram_wdata = d_wdata;
    inst_sram_en = i_en; inst_sram_wen = 4'b0; inst_sram_addr = i_addr; inst_sram_wdata = 32'h0;
    #1;
    cnt = 0;
    while (stall_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk({name, " stall cycles"}, 72'(cnt), 72'(exp_stall));
    data_sram_en = 1'b0;
    inst_sram_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] wen;
    logic [1:0] size;
  } wcase_t;

  initial begin : stim
    wcase_t wtab[4];
    wtab[0] = '{4'b1111, 2'd2};
    wtab[1] = '{4'b0101, 2'd2};
    wtab[2] = '{4'b1100, 2'd1};
    wtab[3] = '{4'b1000, 2'd0};

    repeat (3) @(negedge clk);
    #1;
    chk("reset bus_req", 72'(bus_req), 72'(0));
    chk("reset stall_req", 72'(stall_req), 72'(0));
    chk("reset inst_rdata", 72'(inst_sram_rdata), 72'(0));
    chk("reset data_rdata", 72'(data_sram_rdata), 72'(0));
    @(negedge clk);
    rst = 1'b0;

    // Instruction read only.
    push_txn(1'b0, 2'd2, 32'hBFC0_0000, 4'b0, 32'h0);
    rd_q.push_back(32'h3C1D_0000);
    run_group(1'b0, 4'b0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0000, 3, "inst read");
    chk("inst read rdata", 72'(inst_sram_rdata), 72'(32'h3C1D_0000));
    chk("inst read data_rdata", 72'(data_sram_rdata), 72'(0));
    repeat (3) @(negedge clk);
    chk("inst rdata hold", 72'(inst_sram_rdata), 72'(32'h3C1D_0000));

    // Data half write plus instruction read: data goes first.
    push_txn(1'b1, 2'd1, 32'h8000_1000, 4'b0011, 32'h1234_ABCD);
    push_txn(1'b0, 2'd2, 32'hBFC0_0004, 4'b0, 32'h0);
    rd_q.push_back(32'h8C08_0000);
    run_group(1'b1, 4'b0011, 32'h8000_1000, 32'h1234_ABCD, 1'b1, 32'hBFC0_0004, 5, "dual");
    chk("dual data_rdata", 72'(data_sram_rdata), 72'(0));
    chk("dual inst_rdata", 72'(inst_sram_rdata), 72'(32'h8C08_0000));

    // Slow slave: addr_ok held off for 3 cycles.
    addr_delay = 3;
    push_txn(1'b0, 2'd2, 32'h8000_2000, 4'b0, 32'h0);
    rd_q.push_back(32'hCAFE_F00D);
    run_group(1'b1, 4'b0, 32'h8000_2000, 32'h0, 1'b0, 32'h0, 6, "slow read");
    chk("slow data_rdata", 72'(data_sram_rdata), 72'(32'hCAFE_F00D));
    addr_delay = 0;

    // Byte write must not disturb data rdata.
    push_txn(1'b1, 2'd0, 32'h8000_0003, 4'b0100, 32'h00AA_0000);
    run_group(1'b1, 4'b0100, 32'h8000_0003, 32'h00AA_0000, 1'b0, 32'h0, 3, "byte write");
    chk("byte write data_rdata", 72'(data_sram_rdata), 72'(32'hCAFE_F00D));

    // Data read leaves inst rdata alone.
    push_txn(1'b0, 2'd2, 32'h8000_0010, 4'b0, 32'h0);
    rd_q.push_back(32'hDEAD_BEEF);
    run_group(1'b1, 4'b0, 32'h8000_0010, 32'h0, 1'b0, 32'h0, 3, "data read");
    chk("data read rdata", 72'(data_sram_rdata), 72'(32'hDEAD_BEEF));
    chk("data read inst_rdata", 72'(inst_sram_rdata), 72'(32'h8C08_0000));

    // Strobe-to-size table.
    foreach (wtab[k]) begin
      push_txn(1'b1, wtab[k].size, 32'h8000_0100 + 32'(k * 4), wtab[k].wen, 32'hA5A5_0000 + 32'(k));
      run_group(1'b1, wtab[k].wen, 32'h8000_0100 + 32'(k * 4), 32'hA5A5_0000 + 32'(k),
                1'b0, 32'h0, 3, "size table");
    end
    chk("size table data_rdata", 72'(data_sram_rdata), 72'(32'hDEAD_BEEF));

    // Spurious data_ok while idle.
    @(negedge clk);
    spur = 1'b1;
    @(posedge clk);
    #2;
    spur = 1'b0;
    @(negedge clk);
    chk("spur stall", 72'(stall_req), 72'(0));
    @(negedge clk);
    chk("spur bus_req", 72'(bus_req), 72'(0));
    chk("spur data_rdata", 72'(data_sram_rdata), 72'(32'hDEAD_BEEF));
    chk("spur inst_rdata", 72'(inst_sram_rdata), 72'(32'h8C08_0000));

    // Reset while waiting for instruction data.
    dok_block = 1'b1;
    push_txn(1'b0, 2'd2, 32'hBFC0_0008, 4'b0, 32'h0);
    @(negedge clk);
    inst_sram_en = 1'b1;
    inst_sram_addr = 32'hBFC0_0008;
    @(negedge clk);
    @(negedge clk);
    chk("I_WAIT stall", 72'(stall_req), 72'(1));
    rst = 1'b1;
    #1;
    chk("async rst bus_req", 72'(bus_req), 72'(0));
    chk("async rst stall", 72'(stall_req), 72'(0));
    chk("async rst inst_rdata", 72'(inst_sram_rdata), 72'(0));
    chk("async rst data_rdata", 72'(data_sram_rdata), 72'(0));
    inst_sram_en = 1'b0;
    dok_block = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post rst bus_req", 72'(bus_req), 72'(0));

    push_txn(1'b0, 2'd2, 32'hBFC0_000C, 4'b0, 32'h0);
    rd_q.push_back(32'h1111_2222);
    run_group(1'b0, 4'b0, 32'h0, 32'h0, 1'b1, 32'hBFC0_000C, 3, "post rst read");
    chk("post rst inst_rdata", 72'(inst_sram_rdata), 72'(32'h1111_2222));
    chk("post rst data_rdata", 72'(data_sram_rdata), 72'(0));

    repeat (4) @(negedge clk);
    chk("leftover expected txns", 72'(exp_q.size()), 72'(0));
    chk("accepted txn count", 72'(n_acc), 72'(n_push));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
